// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU op codes and control-bit positions.
// Imported by the ALU core and the EX/MEM latch.
package exe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [3:0] ALU_LWSW = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_BEQ  = 4'd7;
  localparam logic [3:0] ALU_BNE  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_BAD  = 4'd15;

  // memCtrl = {memRead, memWrite}, wbCtrl = {regWrite, memToReg}
  localparam int MEM_READ_BIT    = 1;
  localparam int MEM_WRITE_BIT   = 0;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

endpackage

// File: rtl/exe_mem_alu_stage_alu_core.sv
// Purely combinational ALU: op, A, B, shamt -> result, zero, illegal.
// Arithmetic wraps; illegal codes yield a zero result.
module alu_core
  import exe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  logic slt_bit;

  assign slt_bit = $signed(a) < $signed(b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_LWSW,
      ALU_ADD:  result = a + b;
      ALU_SUB,
      ALU_BEQ,
      ALU_BNE:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, slt_bit};
      default:  illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exe_mem_alu_stage.sv
// Execute stage: ALU, beq/bne resolution, branch target and the EX/MEM latch.
// Latch priority: reset, flush (bubble), stall (hold), load.
module exe_mem_alu_stage
  import exe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            aluOp,
  input  logic [DATA_W-1:0]     srcA,
  input  logic [DATA_W-1:0]     srcB,
  input  logic [4:0]            shamt,
  input  logic [DATA_W-1:0]     pcPlus4,
  input  logic [DATA_W-1:0]     offset,
  input  logic [REG_ADDR_W-1:0] writeRegIn,
  input  logic [1:0]            memCtrlIn,
  input  logic [1:0]            wbCtrlIn,
  input  logic                  inValid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_W-1:0]     aluResult,
  output logic [DATA_W-1:0]     storeData,
  output logic                  zero,
  output logic                  branchTaken,
  output logic [DATA_W-1:0]     branchTarget,
  output logic [REG_ADDR_W-1:0] writeRegOut,
  output logic [1:0]            memCtrlOut,
  output logic [1:0]            wbCtrlOut,
  output logic                  outValid,
  output logic                  illegalOp
);

  logic [DATA_W-1:0]     alu_res;
  logic                  alu_zero;
  logic                  alu_ill;

  logic [DATA_W-1:0]     res_q, sd_q, tgt_q, tgt_d;
  logic                  zero_q, taken_q, taken_d;
  logic                  valid_q, ill_q, load;
  logic [REG_ADDR_W-1:0] wr_q;
  logic [1:0]            mem_q, wb_q, mem_d, wb_d;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op      (aluOp),
    .a       (srcA),
    .b       (srcB),
    .shamt   (shamt),
    .result  (alu_res),
    .zero    (alu_zero),
    .illegal (alu_ill)
  );

  assign tgt_d   = pcPlus4 + (offset << 2);
  assign taken_d = inValid &
                   (((aluOp == ALU_BEQ) & alu_zero) |
                    ((aluOp == ALU_BNE) & ~alu_zero));
  // bubbles keep their data but never write anything
  assign mem_d   = inValid ? memCtrlIn : 2'b00;
  assign wb_d    = inValid ? wbCtrlIn  : 2'b00;
  assign load    = ~flush & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      sd_q    <= '0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
      wr_q    <= '0;
      mem_q   <= 2'b00;
      wb_q    <= 2'b00;
      valid_q <= 1'b0;
    end else if (flush) begin
      res_q   <= '0;
      sd_q    <= '0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
      wr_q    <= '0;
      mem_q   <= 2'b00;
      wb_q    <= 2'b00;
      valid_q <= 1'b0;
    end else if (!stall) begin
      res_q   <= alu_res;
      sd_q    <= srcB;
      zero_q  <= alu_zero;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
      wr_q    <= writeRegIn;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      valid_q <= inValid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ill_q <= 1'b0;
    else if (load && inValid && alu_ill)
      ill_q <= 1'b1;
  end

  assign aluResult    = res_q;
  assign storeData    = sd_q;
  assign zero         = zero_q;
  assign branchTaken  = taken_q;
  assign branchTarget = tgt_q;
  assign writeRegOut  = wr_q;
  assign memCtrlOut   = mem_q;
  assign wbCtrlOut    = wb_q;
  assign outValid     = valid_q;
  assign illegalOp    = ill_q;

endmodule
